// File: rtl/eth_rx_pkg.sv
// Shared types, constants and the nibble-serial CRC32 step for the MII receive path.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    DATA     = 3'd2,
    FINISH   = 3'd3,
    DROP     = 3'd4
  } rx_state_e;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

  // MSB-first register; reversing the nibble feeds bits in wire order (bit 0 first).
  function automatic logic [31:0] crc32_nibble_step(input logic [31:0] crc,
                                                    input logic [3:0]  nib);
    logic [31:0] c;
    logic [3:0]  r;
    r = {nib[0], nib[1], nib[2], nib[3]};
    c = crc;
    for (int i = 3; i >= 0; i--) begin
      if (c[31] ^ r[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/fcs_byte_delay5.sv
// Five-deep byte delay line that holds back the trailing FCS bytes of a frame.
module fcs_byte_delay5 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic [7:0] oldest_o,
  output logic [2:0] count_o
);

  logic [7:0] mem_q [5];
  logic [2:0] cnt_q;

  // A push into a full line shifts the oldest byte out; pop reads oldest_o and discards the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
      for (int i = 0; i < 5; i++) mem_q[i] <= 8'h00;
    end else if (flush_i || pop_i) begin
      cnt_q <= 3'd0;
    end else if (push_i) begin
      if (cnt_q == 3'd5) begin
        for (int i = 0; i < 4; i++) mem_q[i] <= mem_q[i+1];
        mem_q[4] <= push_data_i;
      end else begin
        for (int i = 0; i < 5; i++) begin
          if (cnt_q == 3'(i)) mem_q[i] <= push_data_i;
        end
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

  assign oldest_o = mem_q[0];
  assign count_o  = cnt_q;

endmodule

// File: rtl/mii_rx_fcs_check.sv
// MII receive front end: preamble/SFD strip, byte assembly, CRC32 check, FCS strip, frame status.
// Optional FCS_RX_STATS_EN adds wrapping good/bad frame counters.
module mii_rx_fcs_check
  import eth_rx_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1522,
  parameter int LEN_W     = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mii_rx_dv,
  input  logic        mii_rx_er,
  input  logic [3:0]  mii_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        align_err,
  output logic        len_err,
  output logic        phy_err,
  output logic [2:0]  dbg_state_o
`ifdef FCS_RX_STATS_EN
  ,
  output logic [31:0] good_cnt,
  output logic [31:0] bad_cnt
`endif
);

  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0] CNT_SAT = '1;

  rx_state_e state_q, state_d;
  logic start_frame, data_nib, finish, track_er;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FINISH decodes its inputs exactly like IDLE so back-to-back preambles are caught.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FINISH: state_d = (mii_rx_dv && mii_rxd == PREAMBLE_NIB) ? PREAMBLE : IDLE;
      PREAMBLE: begin
        if (!mii_rx_dv)                  state_d = IDLE;
        else if (mii_rxd == PREAMBLE_NIB) state_d = PREAMBLE;
        else if (mii_rxd == SFD_NIB)      state_d = DATA;
        else                              state_d = DROP;
      end
      DATA:    if (!mii_rx_dv) state_d = FINISH;
      DROP:    if (!mii_rx_dv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_frame = 1'b0;
    data_nib    = 1'b0;
    finish      = 1'b0;
    track_er    = 1'b0;
    case (state_q)
      IDLE, FINISH: begin
        start_frame = mii_rx_dv && (mii_rxd == PREAMBLE_NIB);
        finish      = (state_q == FINISH);
      end
      PREAMBLE: track_er = 1'b1;
      DATA: begin
        track_er = 1'b1;
        data_nib = mii_rx_dv;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

  logic [31:0]      crc_q, crc_d;
  logic             half_q, half_d;
  logic [3:0]       low_q, low_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             phy_q, phy_d;
  logic             sof_pend_q, sof_pend_d;
  logic [7:0]       oldest;
  logic [2:0]       held;
  logic             byte_done, line_full, emit_push, emit_last, emit;

  assign byte_done = data_nib && half_q;
  assign line_full = (held == 3'd5);
  assign emit_push = byte_done && line_full;
  assign emit_last = finish && line_full;
  assign emit      = emit_push || emit_last;

  fcs_byte_delay5 u_delay (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (start_frame),
    .push_i      (byte_done),
    .push_data_i ({mii_rxd, low_q}),
    .pop_i       (finish),
    .oldest_o    (oldest),
    .count_o     (held)
  );

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d, sof_q, sof_d, eof_q, eof_d, done_q, done_d;
  logic       ok_q, ok_d, crc_err_q, crc_err_d, align_q, align_d;
  logic       len_q, len_d, phy_err_q, phy_err_d;
  logic       crc_bad, len_bad;

  assign crc_bad = (crc_q != CRC_RESIDUE);
  assign len_bad = (cnt_q < MIN_L) || (cnt_q > MAX_L);

  always_comb begin
    crc_d      = crc_q;
    half_d     = half_q;
    low_d      = low_q;
    cnt_d      = cnt_q;
    phy_d      = phy_q;
    sof_pend_d = sof_pend_q;
    if (start_frame) begin
      crc_d      = CRC_INIT;
      half_d     = 1'b0;
      cnt_d      = '0;
      phy_d      = 1'b0;
      sof_pend_d = 1'b1;
    end else begin
      if (data_nib) begin
        crc_d  = crc32_nibble_step(crc_q, mii_rxd);
        half_d = ~half_q;
        if (!half_q) low_d = mii_rxd;
        if (half_q && cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
      end
      if (track_er && mii_rx_er) phy_d = 1'b1;
      if (emit) sof_pend_d = 1'b0;
    end
    // rx_valid is a one-cycle strobe with no ready; every strobe must be taken downstream.
    valid_d   = emit;
    data_d    = emit ? oldest : data_q;
    sof_d     = emit && sof_pend_q;
    eof_d     = emit_last;
    done_d    = finish;
    crc_err_d = finish && crc_bad;
    align_d   = finish && half_q;
    len_d     = finish && len_bad;
    phy_err_d = finish && phy_q;
    ok_d      = finish && !(crc_bad || half_q || len_bad || phy_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q      <= CRC_INIT;
      half_q     <= 1'b0;
      low_q      <= 4'h0;
      cnt_q      <= '0;
      phy_q      <= 1'b0;
      sof_pend_q <= 1'b0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      crc_err_q  <= 1'b0;
      align_q    <= 1'b0;
      len_q      <= 1'b0;
      phy_err_q  <= 1'b0;
    end else begin
      crc_q      <= crc_d;
      half_q     <= half_d;
      low_q      <= low_d;
      cnt_q      <= cnt_d;
      phy_q      <= phy_d;
      sof_pend_q <= sof_pend_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      crc_err_q  <= crc_err_d;
      align_q    <= align_d;
      len_q      <= len_d;
      phy_err_q  <= phy_err_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_sof     = sof_q;
  assign rx_eof     = eof_q;
  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign crc_err    = crc_err_q;
  assign align_err  = align_q;
  assign len_err    = len_q;
  assign phy_err    = phy_err_q;

`ifdef FCS_RX_STATS_EN
  logic [31:0] good_q, bad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_q <= 32'd0;
      bad_q  <= 32'd0;
    end else if (finish) begin
      if (ok_d) good_q <= good_q + 32'd1;
      else      bad_q  <= bad_q + 32'd1;
    end
  end

  assign good_cnt = good_q;
  assign bad_cnt  = bad_q;
`endif

endmodule

// File: doc/mii_rx_fcs_check.md
Name: mii_rx_fcs_check

Overview:
- Receive-side counterpart of the team's nibble-wide CRC32 generator.
- Sits between the MII receive pins (rx_clk domain) and the Ethernet RX parser.
- Strips preamble/SFD, assembles nibbles into bytes, runs CRC32 over the frame including FCS, and strips the 4 FCS bytes.
- Delivers a byte stream with per-frame status: CRC, alignment, length, PHY error.

Parameters:
- MIN_FRAME, 64, minimum legal frame length in bytes (DA through FCS inclusive)
- MAX_FRAME, 1522, maximum legal frame length in bytes (DA through FCS inclusive)
- LEN_W, 11, width of byte counter; saturates at 2^LEN_W-1

Ports:
- clk  in  1  MII receive clock, one nibble per cycle (already decided)
- rst_n  in  1  asynchronous, active-low reset (already decided)
- mii_rx_dv  in  1  MII receive data valid
- mii_rx_er  in  1  MII receive error
- mii_rxd  in  4  MII nibble, low nibble of each byte first
- rx_data  out  8  payload byte (FCS stripped)
- rx_valid  out  1  rx_data valid, one-cycle strobe
- rx_sof  out  1  with rx_valid, first payload byte
- rx_eof  out  1  with rx_valid, last payload byte
- frame_done  out  1  one-cycle pulse; status outputs valid this cycle
- frame_ok  out  1  no error flag set
- crc_err  out  1  residue mismatch
- align_err  out  1  odd nibble count after SFD
- len_err  out  1  length < MIN_FRAME or > MAX_FRAME
- phy_err  out  1  mii_rx_er seen during frame

Behaviour:
- Reset: all outputs 0.
  - State IDLE, CRC register 32'hFFFFFFFF, counters 0, delay line empty.
- FSM:
  - IDLE: rx_dv=1 and rxd=4'h5 -> PREAMBLE.
  - PREAMBLE:
    - rxd=4'h5 stays.
    - rxd=4'hD -> DATA.
    - Any other nibble -> DROP.
    - rx_dv=0 -> IDLE with no frame_done.
  - DATA: rx_dv=0 -> FINISH.
  - FINISH: one cycle; emits the final byte and status -> IDLE.
  - DROP: wait for rx_dv=0 -> IDLE; no output, no frame_done.
- CRC:
  - Non-reflected register; each DATA nibble is bit-reversed before the step.
  - Polynomial 0x04C11DB7.
  - Updated on every DATA nibble, FCS included.
  - Good frame iff register == 32'hC704DD7B at FINISH.
- Byte assembly:
  - First nibble is the low half, second nibble the high half.
  - Byte complete on the second nibble; byte counter increments (saturating).
- FCS stripping, 5-entry byte delay line:
  - When a new byte completes with 5 held, the oldest is emitted next cycle.
  - rx_sof is set on the first byte emitted in a frame.
  - In FINISH, if ≥5 bytes are held, the oldest is emitted with rx_eof=1, in the same cycle as frame_done. The remaining 4 bytes (FCS) are discarded.
  - Frames of ≤4 bytes emit no data; frame_done still pulses with len_err=1.
  - A 5-byte frame emits one byte with rx_sof=rx_eof=1.
- Status, all computed at FINISH:
  - align_err: a leftover half-byte exists. The partial nibble is dropped; the CRC still includes it.
  - phy_err: rx_er=1 on any cycle in PREAMBLE or DATA.
  - frame_ok = ~(crc_err|align_err|len_err|phy_err).
- Latency: first payload byte appears 1 clk after the 6th data byte completes.
- Back-to-back frames:
  - rx_dv returning high in FINISH is treated as IDLE input (a new preamble is accepted).
  - The delay line and CRC are cleared on entering PREAMBLE.
- Async reset mid-frame: abort immediately, no frame_done. Resume on the next preamble.
- No backpressure; the downstream block must accept one byte per 2 clks.

Optional Feature:
- FCS_RX_STATS_EN defined:
  - Adds outputs good_cnt[31:0] and bad_cnt[31:0], both wrapping.
  - Incremented at frame_done by frame_ok / ~frame_ok.
  - Reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package eth_rx_pkg:
  - FSM state enum (IDLE, PREAMBLE, DATA, FINISH, DROP).
  - Constants: PREAMBLE_NIB=4'h5, SFD_NIB=4'hD, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hC704DD7B.
  - Function crc32_nibble_step(crc, nib).
- Sub-module fcs_byte_delay5:
  - 5-deep byte shift register with occupancy count.
  - Ports: push, flush, pop-oldest-on-finish.

Test Plan:
- 64-byte frame (7×0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS) -> 60 rx_valid strobes, sof on 0x00, eof on 0x3B, frame_ok=1.
- Same frame with payload byte 10 bit 0 flipped -> same 60 bytes, crc_err=1, frame_ok=0.
- 60-byte frame, correct FCS -> 56 bytes out, len_err=1, crc_err=0.
- Valid frame plus one extra nibble 4'h3 before rx_dv drops -> align_err=1.
- rx_er pulsed 1 cycle mid-payload -> phy_err=1; separately, preamble with nibble 4'hA -> no output, no frame_done.
- Two 64-byte good frames, 12-cycle IPG, then async reset mid-third frame -> two frame_done with frame_ok=1, no third frame_done; with FCS_RX_STATS_EN, good_cnt=2 before reset, 0 after.
